multi_mode_sequencer: RTL and testbench

//  Parametrised mode sequencer for the multi-function timer top. It cycles among N_MODES

---
 rtl/multi_mode_sequencer.sv | 175 +++++++++++++++++
 tb/tb_multi_mode_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_mode_sequencer.sv
// Mode sequencer: steps among N_MODES channels on mode_btn, routes buttons/value to the active channel, drives a breathing RGB LED.
// Mode steps 3 clk after mode_btn rises; buttons/value/LED/clr are 1-cycle registered; no backpressure, every input is consumed each cycle.
module multi_mode_sequencer #(
  parameter int                   N_MODES      = 3,
  parameter int                   VALUE_W      = 16,
  parameter int                   BTN_W        = 3,
  parameter int                   PWM_PERIOD   = 10000,
  parameter int                   BREATH_STEP  = 1000000,
  parameter logic [3*N_MODES-1:0] MODE_COLOR   = 9'b001_010_100,
  parameter bit                   CLR_ON_ENTRY = 1'b1,
  localparam int                  MW           = (N_MODES > 1) ? $clog2(N_MODES) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       mode_btn,
  input  logic [BTN_W-1:0]           btn,
  input  logic [N_MODES*VALUE_W-1:0] ch_value,
  input  logic [N_MODES-1:0]         ch_active,
  output logic [N_MODES*BTN_W-1:0]   ch_btn,
  output logic [N_MODES-1:0]         ch_clr,
  output logic [MW-1:0]              mode,
  output logic                       mode_chg,
  output logic [VALUE_W-1:0]         value,
  output logic                       led_r,
  output logic                       led_g,
  output logic                       led_b
);

  localparam int              PW        = $clog2(PWM_PERIOD + 1);
  localparam int              SW        = $clog2(BREATH_STEP + 1);
  localparam int              DUTY_UNIT = PWM_PERIOD / 100;
  localparam logic [MW-1:0]   MODE_LAST = MW'(N_MODES - 1);
  localparam logic [PW-1:0]   PWM_LAST  = PW'(PWM_PERIOD - 1);
  localparam logic [SW-1:0]   STEP_LAST = SW'(BREATH_STEP - 1);

  typedef enum logic {
    BR_UP   = 1'b0,
    BR_DOWN = 1'b1
  } breath_e;

  logic                     mb_s1, mb_s2, mb_s3;
  logic                     mode_rise;
  logic                     lock_q;
  logic [N_MODES*BTN_W-1:0] btn_nxt;
  logic [N_MODES-1:0]       clr_nxt;
  logic [VALUE_W-1:0]       value_nxt;
  logic [PW-1:0]            pwm_cnt;
  logic [PW-1:0]            pwm_thr;
  logic                     pwm_on;
  logic [SW-1:0]            step_cnt;
  logic                     step_wrap;
  logic [6:0]               duty;
  breath_e                  br_state, br_next;
  logic [2:0]               col;
  logic [2:0]               led_nxt;

  // mb_s3 holds the previous synchronised level for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mb_s1 <= 1'b0;
      mb_s2 <= 1'b0;
      mb_s3 <= 1'b0;
    end else begin
      mb_s1 <= mode_btn;
      mb_s2 <= mb_s1;
      mb_s3 <= mb_s2;
    end
  end

  assign mode_rise = mb_s2 & ~mb_s3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode     <= '0;
      mode_chg <= 1'b0;
    end else begin
      mode_chg <= mode_rise;
      if (mode_rise) begin
        mode <= (mode == MODE_LAST) ? '0 : mode + MW'(1);
      end
    end
  end

  // A button held across a mode step stays blocked until released once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q <= 1'b0;
    end else if (mode_rise) begin
      lock_q <= |btn;
    end else if (~|btn) begin
      lock_q <= 1'b0;
    end
  end

  always_comb begin
    btn_nxt = '0;
    if (!mode_rise && !lock_q) begin
      btn_nxt[BTN_W*mode +: BTN_W] = btn;
    end
  end

  always_comb begin
    clr_nxt = '0;
    if (CLR_ON_ENTRY && mode_chg) begin
      clr_nxt[mode] = 1'b1;
    end
  end

  assign value_nxt = ch_value[VALUE_W*mode +: VALUE_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_btn <= '0;
      ch_clr <= '0;
      value  <= '0;
    end else begin
      ch_btn <= btn_nxt;
      ch_clr <= clr_nxt;
      value  <= value_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt  <= '0;
      step_cnt <= '0;
    end else begin
      pwm_cnt  <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + PW'(1);
      step_cnt <= step_wrap ? '0 : step_cnt + SW'(1);
    end
  end

  assign step_wrap = (step_cnt == STEP_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_state <= BR_UP;
    end else begin
      br_state <= br_next;
    end
  end

  // Direction flips on the step that lands duty on 100 or 0
  always_comb begin
    br_next = br_state;
    case (br_state)
      BR_UP:   if (step_wrap && duty == 7'd99) br_next = BR_DOWN;
      BR_DOWN: if (step_wrap && duty == 7'd1)  br_next = BR_UP;
      default: br_next = BR_UP;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty <= '0;
    end else if (step_wrap) begin
      duty <= (br_state == BR_UP) ? duty + 7'd1 : duty - 7'd1;
    end
  end

  assign pwm_thr = PW'(int'(duty) * DUTY_UNIT);
  assign pwm_on  = (pwm_cnt < pwm_thr);

  assign col     = MODE_COLOR[3*mode +: 3];
  assign led_nxt = ch_active[mode] ? (col & {3{pwm_on}}) : col;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {led_r, led_g, led_b} <= 3'b000;
    end else begin
      {led_r, led_g, led_b} <= led_nxt;
    end
  end

endmodule

// File: tb/tb_multi_mode_sequencer.sv
// Bench for multi_mode_sequencer with a fast PWM/breathing configuration.
module tb_multi_mode_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mode_btn;
  logic [2:0]  btn;
  logic [47:0] ch_value;
  logic [2:0]  ch_active;
  logic [8:0]  ch_btn;
  logic [2:0]  ch_clr;
  logic [1:0]  mode;
  logic        mode_chg;
  logic [15:0] value;
  logic        led_r, led_g, led_b;

  int checks = 0;
  int failures = 0;
  int presses = 0;
  int cyc = 0;

  multi_mode_sequencer #(
    .N_MODES(3), .VALUE_W(16), .BTN_W(3), .PWM_PERIOD(100), .BREATH_STEP(4),
    .MODE_COLOR(9'b001_010_100), .CLR_ON_ENTRY(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .mode_btn(mode_btn), .btn(btn),
    .ch_value(ch_value), .ch_active(ch_active), .ch_btn(ch_btn), .ch_clr(ch_clr),
    .mode(mode), .mode_chg(mode_chg), .value(value),
    .led_r(led_r), .led_g(led_g), .led_b(led_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  function automatic logic [15:0] slice_val(input int m);
    return ch_value[16*m +: 16];
  endfunction

  function automatic int tri_duty(input int k);
    int p;
    p = k % 200;
    return (p <= 100) ? p : 200 - p;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One mode_btn press followed by a release gap; records what the DUT did.
  task automatic press(output int chg_at, output int chg_cnt, output logic [1:0] m_after,
                       output logic [2:0] clr_after, output logic [15:0] val_before,
                       output logic [15:0] val_after);
    mode_btn = 1'b1;
    chg_at = -1; chg_cnt = 0; m_after = '0; clr_after = '0; val_before = '0; val_after = '0;
    for (int i = 1; i <= 6; i++) begin
      tick;
      if (mode_chg) begin
        chg_cnt++;
        if (chg_at < 0) chg_at = i;
      end
      if (i == 3) val_before = value;
      if (i == 4) begin
        clr_after = ch_clr;
        val_after = value;
        m_after   = mode;
      end
    end
    mode_btn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (mode_chg) chg_cnt++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b1; mode_btn = 1'b0; btn = '0; ch_active = '0;
    ch_value = {16'h0003, 16'h0002, 16'h0001};
    #2 reset_n = 1'b0;
    #2;
    checks++; if (mode !== 2'd0)        begin failures++; $display("FAIL reset_mode got=%0h exp=0", mode); end
    checks++; if (mode_chg !== 1'b0)    begin failures++; $display("FAIL reset_mode_chg got=%0h exp=0", mode_chg); end
    checks++; if (ch_btn !== 9'd0)      begin failures++; $display("FAIL reset_ch_btn got=%0h exp=0", ch_btn); end
    checks++; if (ch_clr !== 3'd0)      begin failures++; $display("FAIL reset_ch_clr got=%0h exp=0", ch_clr); end
    checks++; if (value !== 16'd0)      begin failures++; $display("FAIL reset_value got=%0h exp=0", value); end
    checks++; if ({led_r, led_g, led_b} !== 3'b000)
      begin failures++; $display("FAIL reset_led got=%0b exp=000", {led_r, led_g, led_b}); end
    tick; tick;
    reset_n = 1'b1;
    presses = 0;
    tick;
    checks++; if (value !== 16'h0001) begin failures++; $display("FAIL release_value got=%0h exp=1", value); end
    checks++; if (mode !== 2'd0)      begin failures++; $display("FAIL release_mode got=%0h exp=0", mode); end
  endtask

  task automatic test_mode_step;
    int chg_at, chg_cnt, n, prev;
    logic [1:0] m; logic [2:0] clr; logic [15:0] vb, va;
    for (int pass = 0; pass < 2; pass++) begin
      n = (pass == 0) ? 4 : $urandom_range(2, 5);
      if (pass == 1) ch_value = {16'($urandom), 16'($urandom), 16'($urandom)};
      for (int p = 0; p < n; p++) begin
        prev = presses % 3;
        press(chg_at, chg_cnt, m, clr, vb, va);
        presses++;
        checks++; if (chg_at !== 3) begin failures++; $display("FAIL step_latency got=%0d exp=3", chg_at); end
        checks++; if (chg_cnt !== 1) begin failures++; $display("FAIL step_chg_pulses got=%0d exp=1", chg_cnt); end
        checks++; if (m !== 2'(presses % 3)) begin failures++; $display("FAIL step_mode got=%0d exp=%0d", m, presses % 3); end
        checks++; if (clr !== 3'(1 << (presses % 3)))
          begin failures++; $display("FAIL step_clr got=%0b exp=%0b", clr, 3'(1 << (presses % 3))); end
        checks++; if (vb !== slice_val(prev)) begin failures++; $display("FAIL value_old got=%0h exp=%0h", vb, slice_val(prev)); end
        checks++; if (va !== slice_val(presses % 3))
          begin failures++; $display("FAIL value_new got=%0h exp=%0h", va, slice_val(presses % 3)); end
      end
    end
  endtask

  task automatic test_buttons;
    int chg_at, chg_cnt, b;
    logic [1:0] m; logic [2:0] clr; logic [15:0] vb, va; logic [8:0] seen;
    for (int g = 0; g < 3 && (presses % 3) != 1; g++) begin
      press(chg_at, chg_cnt, m, clr, vb, va);
      presses++;
    end
    checks++; if (mode !== 2'd1) begin failures++; $display("FAIL btn_setup_mode got=%0d exp=1", mode); end
    for (int i = 0; i < 8; i++) begin
      b = $urandom_range(1, 7);
      btn = 3'(b);
      tick;
      checks++; if (ch_btn !== (9'(b) << 3))
        begin failures++; $display("FAIL btn_route got=%0h exp=%0h", ch_btn, 9'(b) << 3); end
    end
    btn = 3'b010;
    tick;
    checks++; if (ch_btn !== 9'b000_010_000) begin failures++; $display("FAIL btn_slice1 got=%0b exp=000010000", ch_btn); end
    press(chg_at, chg_cnt, m, clr, vb, va);
    presses++;
    checks++; if (mode !== 2'd2) begin failures++; $display("FAIL btn_hold_mode got=%0d exp=2", mode); end
    seen = ch_btn;
    for (int i = 0; i < 5; i++) begin tick; seen |= ch_btn; end
    checks++; if (seen !== 9'd0) begin failures++; $display("FAIL btn_lockout got=%0h exp=0", seen); end
    btn = 3'b000;
    tick;
    btn = 3'b001;
    tick;
    checks++; if (ch_btn !== 9'b001_000_000) begin failures++; $display("FAIL btn_after_release got=%0b exp=001000000", ch_btn); end
    btn = 3'b000;
    tick;
  endtask

  task automatic test_hold_and_coincident;
    int cnt;
    logic [8:0] seen;
    cnt = 0;
    mode_btn = 1'b1;
    for (int i = 0; i < 1000; i++) begin tick; if (mode_chg) cnt++; end
    mode_btn = 1'b0;
    for (int i = 0; i < 3; i++) begin tick; if (mode_chg) cnt++; end
    presses++;
    checks++; if (cnt !== 1) begin failures++; $display("FAIL hold_steps got=%0d exp=1", cnt); end
    checks++; if (mode !== 2'(presses % 3)) begin failures++; $display("FAIL hold_mode got=%0d exp=%0d", mode, presses % 3); end
    seen = '0;
    mode_btn = 1'b1;
    tick; seen |= ch_btn;
    tick; seen |= ch_btn;
    btn = 3'b100;
    for (int i = 0; i < 8; i++) begin tick; seen |= ch_btn; end
    btn = 3'b000;
    mode_btn = 1'b0;
    for (int i = 0; i < 3; i++) begin tick; seen |= ch_btn; end
    presses++;
    checks++; if (seen !== 9'd0) begin failures++; $display("FAIL coincident_btn got=%0h exp=0", seen); end
    checks++; if (mode !== 2'(presses % 3)) begin failures++; $display("FAIL coincident_mode got=%0d exp=%0d", mode, presses % 3); end
  endtask

  task automatic test_reset_mid;
    int chg_at, chg_cnt;
    logic [1:0] m; logic [2:0] clr; logic [15:0] vb, va;
    for (int g = 0; g < 3 && (presses % 3) != 2; g++) begin
      press(chg_at, chg_cnt, m, clr, vb, va);
      presses++;
    end
    checks++; if (mode !== 2'd2) begin failures++; $display("FAIL mid_setup_mode got=%0d exp=2", mode); end
    ch_active = 3'b111;
    btn = 3'b011;
    tick; tick;
    #1 reset_n = 1'b0;
    #1;
    checks++; if ({mode, mode_chg, ch_btn, ch_clr, value, led_r, led_g, led_b} !== '0)
      begin failures++; $display("FAIL mid_reset_outputs got=%0h exp=0",
                                  {mode, mode_chg, ch_btn, ch_clr, value, led_r, led_g, led_b}); end
    btn = 3'b000;
    #1 reset_n = 1'b1;
    presses = 0;
    tick;
    checks++; if (value !== ch_value[15:0]) begin failures++; $display("FAIL mid_release_value got=%0h exp=%0h", value, ch_value[15:0]); end
    press(chg_at, chg_cnt, m, clr, vb, va);
    presses++;
    checks++; if (m !== 2'd1) begin failures++; $display("FAIL mid_first_step got=%0d exp=1", m); end
    ch_active = 3'b000;
  endtask

  task automatic test_breathing;
    int n, d;
    logic exp_r;
    int chg_at, chg_cnt;
    logic [1:0] m; logic [2:0] clr; logic [15:0] vb, va;
    ch_active = 3'b001;
    tick;
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    presses = 0;
    for (int i = 0; i < 820; i++) begin
      tick;
      n = cyc;
      d = tri_duty((n - 1) / 4);
      exp_r = (((n - 1) % 100) < d);
      checks++; if (led_r !== exp_r)
        begin failures++; $display("FAIL breath_r cyc=%0d got=%0b exp=%0b duty=%0d", n, led_r, exp_r, d); end
      checks++; if ({led_g, led_b} !== 2'b00)
        begin failures++; $display("FAIL breath_gb cyc=%0d got=%0b exp=00", n, {led_g, led_b}); end
    end
    ch_active = 3'b000;
    tick; tick;
    checks++; if ({led_r, led_g, led_b} !== 3'b100) begin failures++; $display("FAIL steady_red got=%0b exp=100", {led_r, led_g, led_b}); end
    press(chg_at, chg_cnt, m, clr, vb, va);
    presses++;
    checks++; if ({led_r, led_g, led_b} !== 3'b010) begin failures++; $display("FAIL steady_green got=%0b exp=010", {led_r, led_g, led_b}); end
    press(chg_at, chg_cnt, m, clr, vb, va);
    presses++;
    checks++; if ({led_r, led_g, led_b} !== 3'b001) begin failures++; $display("FAIL steady_blue got=%0b exp=001", {led_r, led_g, led_b}); end
  endtask

  initial begin
    test_reset;
    test_mode_step;
    test_buttons;
    test_hold_and_coincident;
    test_reset_mid;
    test_breathing;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
